fire5_squeeze_fmap_buf: RTL and testbench

- Feature-map buffer directly downstream of the fire5 squeeze layer.
- Captures each 32-channel output vector the squeeze layer presents on its sample strobe, one vector per output pixel, into a pixel-major RAM.
- Pulses ram_feedback once the full WOUT×WOUT map is stored.
- Then streams the map back one 16-bit value per cycle, channel-fastest, to the fire5 1×1 expand stage, whose CHIN equals DSP_NO.

---
 rtl/fire_pkg.sv | 13 +
 rtl/fmap_ram.sv | 29 ++
 rtl/fire5_squeeze_fmap_buf.sv | 115 +++++++++++
 tb/tb_fire5_squeeze_fmap_buf.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared types and constants for the fire5 feature-map buffering blocks.
package fire_pkg;
  localparam int ACT_W = 16;

  typedef logic [ACT_W-1:0] act_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fmap_state_e;
endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// There is no reset, so the storage can map onto block RAM.
module fmap_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fire5_squeeze_fmap_buf.sv
// Captures fire5 squeeze output vectors into a pixel-major RAM, then streams
// the map back one activation per accepted request, channel-fastest.
module fire5_squeeze_fmap_buf
  import fire_pkg::*;
#(
  parameter  int WIDTH  = ACT_W,
  parameter  int DSP_NO = 32,
  parameter  int WOUT   = 32,
  localparam int NPIX   = WOUT * WOUT,
  localparam int PIX_AW = $clog2(NPIX),
  localparam int CH_AW  = $clog2(DSP_NO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_in,
  input  logic [WIDTH-1:0] ofm_in [0:DSP_NO-1],
  input  logic             rd_en,
  output logic [WIDTH-1:0] ifm_out,
  output logic             ifm_valid,
  output logic             ram_feedback,
  output logic             rd_done,
  output logic             overflow
);
  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NPIX - 1);
  localparam logic [CH_AW-1:0]  LAST_CH  = CH_AW'(DSP_NO - 1);

  fmap_state_e r_state, w_next;
  logic [PIX_AW-1:0] r_wr_ptr, r_rd_pix;
  logic [CH_AW-1:0]  r_rd_ch, r_ch_s1;
  logic              r_v1, r_last1;
  logic [DSP_NO*WIDTH-1:0] w_wdata, w_rdata;
  logic w_we, w_last_wr, w_rd_acc, w_last_rd;

  assign w_we      = sample_in && (r_state == FILL);
  assign w_last_wr = w_we && (r_wr_ptr == LAST_PIX);
  assign w_rd_acc  = rd_en && ((r_state == FULL) || (r_state == DRAIN));
  assign w_last_rd = w_rd_acc && (r_rd_pix == LAST_PIX) && (r_rd_ch == LAST_CH);

  // Channel 0 occupies the least-significant slice of the RAM word.
  always_comb begin
    w_wdata = '0;
    for (int c = 0; c < DSP_NO; c++) begin
      w_wdata[c*WIDTH +: WIDTH] = ofm_in[c];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    w_next = w_last_wr ? FULL : FILL;
      FULL:    w_next = w_last_rd ? DONE : (rd_en ? DRAIN : FULL);
      DRAIN:   w_next = w_last_rd ? DONE : DRAIN;
      DONE:    w_next = DONE;
      default: w_next = FILL;
    endcase
  end

  fmap_ram #(
    .DEPTH(NPIX),
    .DW   (DSP_NO * WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(w_wdata),
    .i_re   (w_rd_acc),
    .i_raddr(r_rd_pix),
    .o_rdata(w_rdata)
  );

  // Stage 1 is the RAM read plus r_ch_s1; stage 2 selects the channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_rd_pix     <= '0;
      r_rd_ch      <= '0;
      r_ch_s1      <= '0;
      r_v1         <= 1'b0;
      r_last1      <= 1'b0;
      ifm_out      <= '0;
      ifm_valid    <= 1'b0;
      ram_feedback <= 1'b0;
      rd_done      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PIX_AW'(1);
      end
      if (w_rd_acc) begin
        r_ch_s1 <= r_rd_ch;
        if (r_rd_ch == LAST_CH) begin
          r_rd_ch  <= '0;
          r_rd_pix <= r_rd_pix + PIX_AW'(1);
        end else begin
          r_rd_ch <= r_rd_ch + CH_AW'(1);
        end
      end
      r_v1      <= w_rd_acc;
      r_last1   <= w_last_rd;
      ifm_valid <= r_v1;
      if (r_v1) begin
        ifm_out <= w_rdata[r_ch_s1*WIDTH +: WIDTH];
      end
      ram_feedback <= w_last_wr;
      if (sample_in && (r_state != FILL)) begin
        overflow <= 1'b1;
      end
      if (r_v1 && r_last1) begin
        rd_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fire5_squeeze_fmap_buf.sv
// Directed bench: small 4x4x4 instance checked against a queue-based model,
// plus a default-parameter instance streamed against random fill data.
module tb_fire5_squeeze_fmap_buf;
  localparam int D = 4, WO = 4, N = WO * WO, TOT = N * D;
  localparam int BD = 32, BWO = 32, BN = BWO * BWO, BTOT = BN * BD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, sample_in = 1'b0, rd_en = 1'b0;
  logic [15:0] ofm_in [0:D-1];
  logic [15:0] ifm_out;
  logic        ifm_valid, ram_feedback, rd_done, overflow;

  logic        b_rst = 1'b1, b_sample = 1'b0, b_rd_en = 1'b0;
  logic [15:0] b_ofm [0:BD-1];
  logic [15:0] b_out;
  logic        b_valid, b_fb, b_done, b_ovf;

  fire5_squeeze_fmap_buf #(.WIDTH(16), .DSP_NO(D), .WOUT(WO)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .ofm_in(ofm_in), .rd_en(rd_en),
    .ifm_out(ifm_out), .ifm_valid(ifm_valid), .ram_feedback(ram_feedback),
    .rd_done(rd_done), .overflow(overflow));

  fire5_squeeze_fmap_buf dut_big (
    .clk(clk), .rst(b_rst), .sample_in(b_sample), .ofm_in(b_ofm), .rd_en(b_rd_en),
    .ifm_out(b_out), .ifm_valid(b_valid), .ram_feedback(b_fb),
    .rd_done(b_done), .overflow(b_ovf));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stored vectors, expected stream queue with due edge.
  typedef struct {
    logic [15:0] v;
    int          due;
    bit          last;
  } exp_t;

  logic [15:0] mmem [0:N-1][0:D-1];
  exp_t q[$];
  int  nwr = 0, nrd = 0, ecnt = 0, last_due = -1;
  bit  mfb = 1'b0, movf = 1'b0, mdone = 1'b0, chk_en = 1'b0;

  always @(posedge clk) begin
    bit full;
    ecnt++;
    if (rst) begin
      nwr = 0; nrd = 0; q.delete();
      mfb = 1'b0; movf = 1'b0; mdone = 1'b0; last_due = -1;
    end else begin
      full = (nwr == N);
      mfb  = 1'b0;
      if (ecnt == last_due) mdone = 1'b1;
      if (rd_en && full && nrd < TOT) begin
        q.push_back('{v: mmem[nrd / D][nrd % D], due: ecnt + 1, last: (nrd == TOT - 1)});
        if (nrd == TOT - 1) last_due = ecnt + 1;
        nrd++;
      end
      if (sample_in) begin
        if (full) begin
          movf = 1'b1;
        end else begin
          for (int c = 0; c < D; c++) mmem[nwr][c] = ofm_in[c];
          nwr++;
          if (nwr == N) mfb = 1'b1;
        end
      end
    end
  end

  int got_n = 0, fb_cnt = 0, first_edge = -1;
  logic [15:0] got [0:TOT-1];

  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (chk_en) begin
      ev = (q.size() > 0) && (q[0].due == ecnt);
      chk("ifm_valid", ifm_valid, ev);
      if (ev) begin
        e = q.pop_front();
        chk("ifm_out", ifm_out, e.v);
      end
      if (ifm_valid === 1'b1) begin
        if (first_edge < 0) first_edge = ecnt;
        if (got_n < TOT) got[got_n] = ifm_out;
        got_n++;
      end
      if (ram_feedback === 1'b1) fb_cnt++;
      chk("ram_feedback", ram_feedback, mfb);
      chk("overflow", overflow, movf);
      chk("rd_done", rd_done, mdone);
    end
  end

  logic [15:0] bmem [0:BN-1][0:BD-1];
  int  bidx = 0;
  bit  b_chk = 1'b0;

  always @(negedge clk) begin
    if (b_chk && b_valid === 1'b1) begin
      if (bidx < BTOT) chk("big_ifm_out", b_out, bmem[bidx / BD][bidx % BD]);
      else chk("big_extra_valid", 32'd1, 32'd0);
      bidx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_in = 1'b0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic fill(input logic [15:0] base, input int gap, input bit rd);
    for (int p = 0; p < N; p++) begin
      for (int c = 0; c < D; c++) ofm_in[c] = 16'(base + 256 * p + c);
      sample_in = 1'b1; rd_en = rd;
      tick();
      sample_in = 1'b0; rd_en = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic wait_drain(input int target, input int budget);
    for (int t = 0; t < budget && got_n < target; t++) tick();
    chk("drain_count_reached", (got_n >= target), 1'b1);
  endtask

  initial begin
    int rise;
    for (int c = 0; c < D; c++) ofm_in[c] = 16'h0;
    for (int c = 0; c < BD; c++) b_ofm[c] = 16'h0;

    // Phase A: spaced fill, dropped 17th sample, held-high drain.
    do_reset();
    chk("reset_valid", ifm_valid, 1'b0);
    chk("reset_fb", ram_feedback, 1'b0);
    fb_cnt = 0; got_n = 0; first_edge = -1;
    fill(16'h0000, 3, 1'b0);
    chk("model_pix5_ch2", mmem[5][2], 16'h0502);
    sample_in = 1'b1;
    for (int c = 0; c < D; c++) ofm_in[c] = 16'hFFFF;
    tick();
    sample_in = 1'b0;
    tick();
    chk("overflow_sticky", overflow, 1'b1);
    rd_en = 1'b1; rise = ecnt;
    wait_drain(TOT, 200);
    repeat (4) tick();
    rd_en = 1'b0;
    tick();
    chk("drain_count", got_n, TOT);
    chk("latency_2", first_edge - rise, 2);
    chk("first_0000", got[0], 16'h0000);
    chk("elem4_0100", got[4], 16'h0100);
    chk("elem63_0F03", got[63], 16'h0F03);
    chk("fb_single_pulse", fb_cnt, 1);
    chk("rd_done_A", rd_done, 1'b1);

    // Phase B: rd_en during fill (ignored, incl. final write), gapped drain.
    do_reset();
    chk("reset_rd_done", rd_done, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    got_n = 0;
    fill(16'h8000, 2, 1'b1);
    chk("no_valid_in_fill", got_n, 0);
    for (int t = 0; t < 400 && got_n < TOT; t++) begin
      rd_en = ~rd_en;
      tick();
    end
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    tick();
    chk("gapped_count", got_n, TOT);
    chk("gapped_first", got[0], 16'h8000);
    chk("gapped_elem37", got[37], 16'h8901);
    chk("gapped_last", got[63], 16'h8F03);

    // Phase C: reset mid-drain, then refill and drain new data.
    do_reset();
    got_n = 0;
    fill(16'h4000, 1, 1'b0);
    rd_en = 1'b1;
    wait_drain(10, 100);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", ifm_valid, 1'b0);
    chk("rst_mid_fb", ram_feedback, 1'b0);
    chk("rst_mid_done", rd_done, 1'b0);
    chk("rst_mid_ovf", overflow, 1'b0);
    rst = 1'b0; rd_en = 1'b0;
    got_n = 0;
    repeat (5) tick();
    chk("no_valid_after_rst", got_n, 0);
    fill(16'h2000, 1, 1'b0);
    rd_en = 1'b1;
    wait_drain(TOT, 200);
    repeat (3) tick();
    rd_en = 1'b0;
    tick();
    chk("refill_first", got[0], 16'h2000);
    chk("refill_last", got[63], 16'h2F03);
    chk("refill_done", rd_done, 1'b1);

    // Phase D: default parameters, random data, full stream.
    b_rst = 1'b0;
    b_chk = 1'b1;
    for (int p = 0; p < BN; p++) begin
      for (int c = 0; c < BD; c++) begin
        b_ofm[c] = 16'($urandom);
        bmem[p][c] = b_ofm[c];
      end
      b_sample = 1'b1;
      tick();
    end
    b_sample = 1'b0;
    b_rd_en = 1'b1;
    for (int t = 0; t < BTOT + 200 && bidx < BTOT; t++) tick();
    repeat (3) tick();
    chk("big_count", bidx, BTOT);
    chk("big_done", b_done, 1'b1);
    chk("big_overflow", b_ovf, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
